// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding bus master for a 16x32 synchronous memory.
// Turns one valid/ready request into a one-cycle wr/rd strobe, waits for the
// memory's registered write response (bounded by TIMEOUT) or captures the
// registered read data, and returns the result on a valid/ready response channel.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | one-cycle mem_wr/mem_rd strobe toward the memory
// WAIT  | write: wait for mem_response or timeout; read: capture mem_rdata
// RSP   | rsp_valid high, fields held until rsp_ready
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  localparam logic [7:0]           TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       lat_write;
  logic [7:0] to_cnt;
  logic [7:0] to_cnt_inc;
  logic       accept;
  logic       wait_done;
  logic       wait_err;
  logic       rsp_fire;

  assign to_cnt_inc = to_cnt + 8'd1;

  // Next-state decode and the one-cycle events the registers below react to
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wait_done = 1'b0;
    wait_err  = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!lat_write) begin
          wait_done = 1'b1;
        end else if (mem_response) begin
          wait_done = 1'b1;
        end else if (to_cnt_inc == TIMEOUT_C) begin
          wait_done = 1'b1;
          wait_err  = 1'b1;
        end
        if (wait_done) begin
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is registered: high exactly while the FSM sits in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (state_nxt == S_IDLE);
    end
  end

  // Latch the request at acceptance; the strobe is registered so it appears during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
      if (accept) begin
        lat_write <= req_write;
        mem_wr    <= req_write;
        mem_rd    <= !req_write;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
    end
  end

  // Counts WAIT cycles spent without a write response
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if ((state == S_WAIT) && lat_write && !wait_done) begin
      to_cnt <= to_cnt_inc;
    end
  end

  // Response channel: fields loaded on leaving WAIT and held until the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (wait_done) begin
      rsp_valid <= 1'b1;
      rsp_write <= lat_write;
      rsp_rdata <= lat_write ? '0 : mem_rdata;
      rsp_err   <= wait_err;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating statistics, bumped on each response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (rsp_fire) begin
      if (txn_count != CNT_MAX) begin
        txn_count <= txn_count + 1'b1;
      end
      if (rsp_err && (err_count != CNT_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl with a behavioural 16x32 memory and a
// transaction-level reference model (array contents, expected latency, counters).
module tb_mem_access_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_response;
  logic [CW-1:0] txn_count;
  logic [CW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [16];
  int exp_txn = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TMO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_wr(mem_wr),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_response(mem_response),
    .txn_count(txn_count),
    .err_count(err_count)
  );

  // Behavioural synchronous memory; rdata shows garbage when not driving a read
  logic [DW-1:0] mem_arr [16];
  logic          mem_resp_en = 1'b1;
  logic          rd_v;
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
      mem_response <= 1'b0;
      rd_v <= 1'b0;
      rd_q <= '0;
    end else begin
      mem_response <= mem_wr && mem_resp_en;
      if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
      rd_v <= mem_rd;
      if (mem_rd) rd_q <= mem_arr[mem_addr];
    end
  end

  assign mem_rdata = rd_v ? rd_q : 32'hBAD0_BAD0;

  task automatic clear_model;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    exp_txn = 0;
    exp_err = 0;
  endtask

  // One full transaction; optionally presents the next request while this one is stalled
  task automatic do_txn(input bit w, input logic [3:0] a, input logic [31:0] d,
                        input int stall, input bit resp_en, input bit preload,
                        input bit pw, input logic [3:0] pa, input logic [31:0] pd);
    int k;
    bit x_err;
    logic [31:0] x_rdata;
    int x_lat;
    mem_resp_en = resp_en;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = (stall == 0);
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: req_ready=%0b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    x_err   = w && !resp_en;
    x_rdata = w ? 32'h0 : ref_mem[a];
    x_lat   = x_err ? 2 + TMO : 3;
    if (w) ref_mem[a] = d;

    @(negedge clk);
    total++;
    if ({mem_wr, mem_rd, mem_addr, req_ready} !== {w, !w, a, 1'b0}) begin
      bad++;
      $display("FAIL issue_strobe: wr=%0b rd=%0b addr=%0h ready=%0b want wr=%0b rd=%0b addr=%0h ready=0",
               mem_wr, mem_rd, mem_addr, req_ready, w, !w, a);
    end
    if (w) begin
      total++;
      if (mem_wdata !== d) begin
        bad++;
        $display("FAIL issue_wdata: got %h want %h", mem_wdata, d);
      end
    end
    if (preload) begin
      req_write = pw;
      req_addr  = pa;
      req_wdata = pd;
    end else begin
      req_valid = 1'b0;
    end

    k = 1;
    do begin
      @(negedge clk);
      k++;
      total++;
      if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
        bad++;
        $display("FAIL strobe_pulse: cycle %0d wr=%0b rd=%0b want 0 0", k, mem_wr, mem_rd);
      end
    end while (rsp_valid !== 1'b1 && k < 300);

    total++;
    if (k != x_lat) begin
      bad++;
      $display("FAIL rsp_latency: got %0d cycles want %0d", k, x_lat);
    end
    if (rsp_valid !== 1'b1) begin
      rsp_ready = 1'b1;
      return;
    end
    total++;
    if ({rsp_write, rsp_err, rsp_rdata} !== {w, x_err, x_rdata}) begin
      bad++;
      $display("FAIL rsp_fields: write=%0b err=%0b rdata=%h want write=%0b err=%0b rdata=%h",
               rsp_write, rsp_err, rsp_rdata, w, x_err, x_rdata);
    end

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, req_ready, mem_wr, mem_rd} !==
          {1'b1, w, x_err, x_rdata, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL rsp_hold: valid=%0b write=%0b err=%0b rdata=%h ready=%0b wr=%0b rd=%0b want 1 %0b %0b %h 0 0 0",
                 rsp_valid, rsp_write, rsp_err, rsp_rdata, req_ready, mem_wr, mem_rd, w, x_err, x_rdata);
      end
    end
    rsp_ready = 1'b1;

    @(negedge clk);
    if (exp_txn < CMAX) exp_txn++;
    if (x_err && exp_err < CMAX) exp_err++;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rsp_release: valid=%0b ready=%0b want 0 1", rsp_valid, req_ready);
    end
    total++;
    if (txn_count !== exp_txn[CW-1:0] || err_count !== exp_err[CW-1:0]) begin
      bad++;
      $display("FAIL counters: txn=%0d err=%0d want txn=%0d err=%0d",
               txn_count, err_count, exp_txn, exp_err);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    mem_resp_en = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_wr, mem_rd,
         mem_addr, mem_wdata, txn_count, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%0b valid=%0b write=%0b rdata=%h err=%0b wr=%0b rd=%0b addr=%h wdata=%h txn=%0d errc=%0d want all 0",
               req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_wr, mem_rd,
               mem_addr, mem_wdata, txn_count, err_count);
    end
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: req_ready=%0b want 1", req_ready);
    end
  endtask

  task automatic test_write_read;
    do_txn(1'b1, 4'h3, 32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    do_txn(1'b0, 4'h3, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_timeout;
    do_txn(1'b1, 4'h7, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    do_txn(1'b0, 4'h7, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    do_txn(1'b1, 4'h0, 32'h0BAD_F00D, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    do_txn(1'b1, 4'hF, 32'h1357_9BDF, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    do_txn(1'b0, 4'h0, 32'h0, 5, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    do_txn(1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_reset_mid;
    int k;
    mem_resp_en = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'h9;
    req_wdata = 32'hCAFE_0009;
    rsp_ready = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_wr, mem_rd,
         mem_addr, mem_wdata, txn_count, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid: ready=%0b valid=%0b write=%0b rdata=%h err=%0b wr=%0b rd=%0b addr=%h wdata=%h txn=%0d errc=%0d want all 0",
               req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_wr, mem_rd,
               mem_addr, mem_wdata, txn_count, err_count);
    end
    reset = 1'b0;
    clear_model();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_rsp: rsp_valid=%0b want 0", rsp_valid);
      end
    end
    do_txn(1'b0, 4'h9, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_addr_f;
    do_txn(1'b1, 4'hF, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    do_txn(1'b0, 4'hF, 32'h0, 2, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             1'b0, 1'b0, 4'h0, 32'h0);
    end
  endtask

  task automatic test_saturation;
    for (int n = 0; n < CMAX + 2; n++) begin
      do_txn(1'b1, 4'($urandom_range(0, 15)), $urandom, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_addr_f();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Upstream bus master for the 16x32 synchronous memory.
- Accepts single read/write requests on a valid/ready request channel and converts each into a one-cycle wr or rd strobe toward the memory.
- Waits for the memory's registered write response, or captures its registered read data.
- Returns each result on a valid/ready response channel, with a timeout-based error flag and transaction/error counters.

Parameters:
- ADDR_WIDTH, 4, memory address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 4, max WAIT cycles for mem_response on a write before error (legal range 1..255).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  echo of req_write for this response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  write timed out.
- mem_wr  out  1  to memory wr.
- mem_rd  out  1  to memory rd.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wdata  out  DATA_WIDTH  to memory wdata.
- mem_rdata  in  DATA_WIDTH  from memory rdata (high-Z when memory output disabled).
- mem_response  in  1  from memory write response.
- txn_count  out  CNT_WIDTH  completed (handshaken) responses, saturating.
- err_count  out  CNT_WIDTH  responses with rsp_err=1, saturating.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All of the following are 0: req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, mem_wr, mem_rd, mem_addr, mem_wdata, txn_count, err_count, timeout counter.
- Reset mid-transaction aborts it: no response is produced, and mem_wr/mem_rd are 0 from the cycle after the reset edge.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write/addr/wdata and go to ISSUE.
  - req_ready drops to 0 in the cycle after acceptance.
- ISSUE (exactly 1 cycle):
  - mem_wr=latched write, mem_rd=!latched write; mem_addr and mem_wdata driven from latch.
  - Go to WAIT.
  - mem_wr and mem_rd are never both 1.
- WAIT, write:
  - mem_wr=0.
  - If mem_response==1: rsp_err=0, go to RSP.
  - Else increment the timeout counter; when it reaches TIMEOUT, set rsp_err=1 and go to RSP.
- WAIT, read (fixed 1 cycle):
  - mem_rd=0.
  - Sample mem_rdata into rsp_rdata, rsp_err=0, go to RSP.
- RSP:
  - rsp_valid=1; rsp_write/rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: txn_count+1 (saturate at all-ones), err_count+1 if rsp_err (saturate), rsp_valid=0, go to IDLE.
- Latency: acceptance edge N -> strobe in cycle N+1 -> rsp_valid high in cycle N+3 on nominal completion. A write that times out raises rsp_valid at N+2+TIMEOUT.
- Throughput: at most one outstanding transaction. Minimum 4 cycles per transaction with rsp_ready tied high.
- mem_addr/mem_wdata hold their last driven values outside ISSUE; no wrap logic, the address passes through unchanged (0xF is a legal address).
- rsp_rdata is forced to 0 for write responses.
- A request presented while not in IDLE is not accepted (req_ready=0); the requester must hold it.

Test Plan:
- Reset, then write addr=0x3 data=0xDEADBEEF with rsp_ready=1 -> mem_wr single-cycle pulse with mem_addr=3; rsp_valid 3 cycles after acceptance; rsp_write=1, rsp_err=0, rsp_rdata=0; txn_count=1.
- Read addr=0x3 after that write -> mem_rd single-cycle pulse; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_write=0; txn_count=2.
- Write with mem_response tied 0, TIMEOUT=4 -> rsp_err=1 exactly 6 cycles after acceptance; err_count=1.
- Back-to-back reads of 0x0 and 0xF with rsp_ready held 0 for 5 cycles on the first -> rsp fields stable throughout; second request not accepted (req_ready=0) until the first is handshaken; both data values correct.
- Assert reset during WAIT of a write -> no rsp_valid; all outputs 0 the next cycle; a subsequent read of the same address returns 0x00000000.
- Write addr=0xF data=0xA5A5A5A5, then read addr=0xF -> rsp_rdata=0xA5A5A5A5; at no point are mem_wr and mem_rd both 1.
